fir_sym_pipe: RTL and testbench

//  Parametrised symmetric (type-I, linear-phase) FIR filter with valid-qualified streaming I/O.
//  It is the next generation of the fixed 8-bit Hamming low-pass, generalised in data width, tap count and coefficient width.

---
 rtl/fir_sym_pipe_pkg.sv | 32 +++
 rtl/fir_sym_pipe_if.sv | 30 +++
 rtl/fir_sym_pipe_adder_tree.sv | 35 +++
 rtl/fir_sym_pipe.sv | 119 +++++++++++
 tb/tb_fir_sym_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_sym_pipe_pkg.sv
// Shared constants and helpers for the symmetric FIR: default Hamming low-pass
// half-table, accumulator sizing and the round/saturate step.
package fir_pkg;

  localparam int HAMMING_NHALF = 8;

  // Q1.8 half-table of a 15-tap Hamming low-pass; 2*sum(c[0..6]) + c[7] = 256
  localparam int HAMMING_LP_COEF [HAMMING_NHALF] = '{1, 3, 6, 12, 20, 29, 37, 40};

  function automatic int acc_width(input int dw, input int cw, input int nhalf);
    return dw + 1 + cw + $clog2(nhalf);
  endfunction

  function automatic int default_coef(input int k);
    return (k >= 0 && k < HAMMING_NHALF) ? HAMMING_LP_COEF[k] : 0;
  endfunction

  // Round half up, drop cfrac fraction bits, clamp to the signed dw-bit range
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int cfrac, input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (cfrac > 0) ? (acc + (64'sd1 <<< (cfrac - 1))) >>> cfrac : acc;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_sym_pipe_if.sv
// Streaming sample bus of fir_sym_pipe. With COEF_LOAD_EN defined it also
// carries the coefficient write port.
interface fir_sym_pipe_if
`ifdef COEF_LOAD_EN
  #(parameter int DW = 8, parameter int CW = 10, parameter int AW = 3);
`else
  #(parameter int DW = 8);
`endif

  logic                 clr;
  logic                 in_valid;
  logic signed [DW-1:0] xn;
  logic                 out_valid;
  logic signed [DW-1:0] yn;

`ifdef COEF_LOAD_EN
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_wdata;

  modport master (output clr, in_valid, xn, coef_we, coef_addr, coef_wdata,
                  input  out_valid, yn);
  modport slave  (input  clr, in_valid, xn, coef_we, coef_addr, coef_wdata,
                  output out_valid, yn);
`else
  modport master (output clr, in_valid, xn, input  out_valid, yn);
  modport slave  (input  clr, in_valid, xn, output out_valid, yn);
`endif

endinterface

// File: rtl/fir_sym_pipe_adder_tree.sv
// Registered binary adder tree: N signed W-bit terms summed combinationally,
// one output register of width W+$clog2(N).
module fir_adder_tree #(
  parameter  int N  = 8,
  parameter  int W  = 19,
  localparam int OW = W + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clr,
  input  logic [N-1:0][W-1:0]  i_din,
  output logic signed [OW-1:0] o_sum
);

  localparam int LV = $clog2(N);
  localparam int P  = 1 << LV;

  logic signed [OW-1:0] w_lvl [LV+1][P];

  // Missing leaves are zero so the tree stays a clean power of two
  always_comb begin
    w_lvl = '{default: '0};
    for (int i = 0; i < N; i++) w_lvl[0][i] = OW'($signed(i_din[i]));
    for (int l = 0; l < LV; l++)
      for (int i = 0; i < (P >> (l + 1)); i++)
        w_lvl[l+1][i] = w_lvl[l][2*i] + w_lvl[l][2*i+1];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   o_sum <= '0;
    else if (clr) o_sum <= '0;
    else          o_sum <= w_lvl[LV][0];
  end

endmodule

// File: rtl/fir_sym_pipe.sv
// Symmetric type-I FIR, 4-stage pipeline (pre-add, multiply, sum, round/sat).
// Define COEF_LOAD_EN to get run-time writable coefficients.
module fir_sym_pipe
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NTAP  = 15,
  parameter int CW    = 10,
  parameter int CFRAC = 8
) (
  input logic           clk,
  input logic           n_rst,
  fir_sym_pipe_if.slave bus
);

  localparam int NHALF = (NTAP + 1) / 2;
  localparam int PW    = DW + 1;
  localparam int MW    = PW + CW;
  localparam int ACCW  = acc_width(DW, CW, NHALF);

  logic signed [DW-1:0]  r_x       [NTAP];
  logic signed [DW-1:0]  w_x_next  [NTAP];
  logic signed [PW-1:0]  w_p       [NHALF];
  logic signed [PW-1:0]  r_p       [NHALF];
  logic signed [CW-1:0]  w_c       [NHALF];
  logic signed [MW-1:0]  r_m       [NHALF];
  logic [NHALF-1:0][MW-1:0] w_tree_in;
  logic signed [ACCW-1:0] w_acc;
  logic [3:0]            r_vld;
  logic signed [DW-1:0]  r_yn;

  // NOTE: every always_comb output is given a default first, so no path can
  // leave it unassigned and no latch is inferred.
  always_comb begin
    w_x_next = r_x;
    if (bus.in_valid) begin
      w_x_next[0] = bus.xn;
      for (int k = 1; k < NTAP; k++) w_x_next[k] = r_x[k-1];
    end
  end

  // S1 pre-adds the post-shift line, so a sample reaches yn four edges after capture
  always_comb begin
    for (int k = 0; k < NHALF - 1; k++)
      w_p[k] = PW'(w_x_next[k]) + PW'(w_x_next[NTAP-1-k]);
    w_p[NHALF-1] = PW'(w_x_next[NHALF-1]);
  end

`ifdef COEF_LOAD_EN
  logic signed [CW-1:0] r_c [NHALF];

  // NOTE: the coefficient bank is reset to the package defaults rather than
  // left uninitialised, so the filter is usable straight out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NHALF; k++) r_c[k] <= CW'(default_coef(k));
    end else if (bus.coef_we && (int'(bus.coef_addr) < NHALF)) begin
      r_c[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  assign w_c = r_c;
`else
  always_comb begin
    for (int k = 0; k < NHALF; k++) w_c[k] = CW'(default_coef(k));
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x <= '{default: '0};
      r_p <= '{default: '0};
      r_m <= '{default: '0};
    end else if (bus.clr) begin
      r_x <= '{default: '0};
      r_p <= '{default: '0};
      r_m <= '{default: '0};
    end else begin
      r_x <= w_x_next;
      r_p <= w_p;
      for (int k = 0; k < NHALF; k++) r_m[k] <= MW'(r_p[k]) * MW'(w_c[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < NHALF; k++) w_tree_in[k] = r_m[k];
  end

  fir_adder_tree #(
    .N (NHALF),
    .W (MW)
  ) u_tree (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (bus.clr),
    .i_din (w_tree_in),
    .o_sum (w_acc)
  );

  // r_vld[2] marks a valid accumulator; yn only moves for valid samples
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vld <= '0;
      r_yn  <= '0;
    end else if (bus.clr) begin
      r_vld <= '0;
      r_yn  <= '0;
    end else begin
      r_vld <= {r_vld[2:0], bus.in_valid};
      if (r_vld[2]) r_yn <= DW'(sat_round(64'(w_acc), CFRAC, DW));
    end
  end

  assign bus.out_valid = r_vld[3];
  assign bus.yn        = r_yn;

endmodule

// File: tb/tb_fir_sym_pipe.sv
// Directed self-checking bench for fir_sym_pipe; coefficient-load steps are
// compiled in when COEF_LOAD_EN is defined.
module tb_fir_sym_pipe;

  localparam int DW    = 8;
  localparam int NTAP  = 15;
  localparam int CW    = 10;
  localparam int CFRAC = 8;
  localparam int AW    = 3;

  // round(127*h[k]/256), round half up, h = full 15-tap default response
  localparam int IMP_EXP [15] = '{0, 1, 3, 6, 10, 14, 18, 20, 18, 14, 10, 6, 3, 1, 0};

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

`ifdef COEF_LOAD_EN
  fir_sym_pipe_if #(.DW(DW), .CW(CW), .AW(AW)) bus ();
`else
  fir_sym_pipe_if #(.DW(DW)) bus ();
`endif

  fir_sym_pipe #(
    .DW    (DW),
    .NTAP  (NTAP),
    .CW    (CW),
    .CFRAC (CFRAC)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ov_first    = -1;
  logic signed [DW-1:0] q [$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] qget(input int k);
    if (k < q.size()) return 32'(q[k]);
    return 'x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_valid === 1'b1) begin
      q.push_back(bus.yn);
      if (ov_first < 0) ov_first = cyc;
    end
  endtask

  task automatic drive(input logic v, input int x);
    bus.in_valid = v;
    bus.xn       = DW'(x);
    tick();
  endtask

  task automatic flush();
    bus.clr      = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.clr      = 1'b0;
  endtask

  task automatic impulse_run(input string tag);
    int c0;
    q.delete();
    ov_first = -1;
    c0 = cyc;
    drive(1'b1, 127);
    repeat (NTAP - 1) drive(1'b1, 0);
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check({tag, "_cnt"}, q.size(), NTAP);
    check({tag, "_lat"}, ov_first - c0, 4);
    for (int k = 0; k < NTAP; k++)
      check($sformatf("%s_y%0d", tag, k), qget(k), IMP_EXP[k]);
  endtask

`ifdef COEF_LOAD_EN
  task automatic write_coef(input int addr, input int data);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = CW'(data);
    tick();
    bus.coef_we    = 1'b0;
  endtask
`endif

  initial begin
    logic        ivh [63];
    logic        exp_ov;
    logic signed [31:0] exp_y;
    int          oi;

    n_rst        = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.xn       = '0;
`ifdef COEF_LOAD_EN
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
`endif
    repeat (3) tick();
    check("rst_ov", bus.out_valid, 0);
    check("rst_yn", bus.yn, 0);
    #2 n_rst = 1'b1;

    // Impulse response after power-up
    impulse_run("imp");

    // DC step: ramp then settle at unity gain
    flush();
    q.delete();
    repeat (30) drive(1'b1, 100);
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("dc_cnt", q.size(), 30);
    check("dc_y0", qget(0), 0);
    check("dc_y1", qget(1), 2);
    check("dc_y2", qget(2), 4);
    for (int k = 14; k < 30; k++) check($sformatf("dc_y%0d", k), qget(k), 100);

    // clr with three samples in flight; a concurrent in_valid is discarded
    repeat (3) drive(1'b1, 100);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.xn       = 8'sd50;
    tick();
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_yn", bus.yn, 0);
    check("clr_ov", bus.out_valid, 0);
    q.delete();
    repeat (6) tick();
    check("clr_drop", q.size(), 0);
    drive(1'b1, 0);
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("clr_cnt", q.size(), 1);
    check("clr_discard", qget(0), 0);

    // Gapped impulse: valid pattern 1,0,0 delayed by four cycles, same values
    flush();
    oi    = 0;
    exp_y = 0;
    for (int j = 0; j < 63; j++) begin
      ivh[j] = (j < 60) && (j % 3 == 0);
      bus.in_valid = ivh[j];
      bus.xn       = (j == 0) ? 8'sd127 : 8'sd0;
      tick();
      exp_ov = (j >= 3) ? ivh[j-3] : 1'b0;
      if (exp_ov) begin
        exp_y = (oi < 15) ? IMP_EXP[oi] : 0;
        oi++;
      end
      check($sformatf("gap_ov%0d", j), bus.out_valid, exp_ov);
      check($sformatf("gap_yn%0d", j), bus.yn, exp_y);
    end
    bus.in_valid = 1'b0;

    // Asynchronous reset mid-stream, then behave as after power-up
    flush();
    repeat (20) drive(1'b1, 100);
    #2 n_rst = 1'b0;
    #1;
    check("arst_ov", bus.out_valid, 0);
    check("arst_yn", bus.yn, 0);
    bus.in_valid = 1'b0;
    tick();
    #2 n_rst = 1'b1;
    impulse_run("arst");

`ifdef COEF_LOAD_EN
    // Saturation with an all-255 half-table
    flush();
    for (int k = 0; k < 8; k++) write_coef(k, 255);
    repeat (20) drive(1'b1, 127);
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("sat_pos", bus.yn, 127);
    repeat (20) drive(1'b1, -128);
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("sat_neg", bus.yn, -128);

    // Rounding with centre tap only at gain 0.5
    for (int k = 0; k < 7; k++) write_coef(k, 0);
    write_coef(7, 128);
    flush();
    repeat (15) drive(1'b1, 3);
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("rnd_pos", bus.yn, 2);
    repeat (15) drive(1'b1, -3);
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("rnd_neg", bus.yn, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
